lcd_text_sequencer: RTL and testbench
=====================================

// Module: lcd_text_sequencer
// PURPOSE
//  Upstream feeder for the I2C byte-write engine driving the serial LCD. Buffers ASCII
//  characters in a FIFO. On flush it runs two I2C write transactions through the
//  byte-level handshake: first a clear (addr, CMD_PREFIX, CLEAR_CMD), then, after a gap,
//  the buffered text (addr, chars...). It reports busy, done and NAK status to the control logic.
// PARAMETERS
//  DEPTH       16      FIFO depth in characters (power of 2, >=2)
//  LCD_ADDR    7'h72   7-bit target address; address byte = {LCD_ADDR,1'b0} = 8'hE4
//  CMD_PREFIX  8'h7C   LCD command-mode prefix byte
//  CLEAR_CMD   8'h2D   LCD clear-display command byte
//  GAP_CYCLES  500     idle clocks between clear STOP and text START
// PORTS
//  clock       in   1      system clock, all logic on posedge
//  reset       in   1      asynchronous, active-low reset
//  char_valid  in   1      push request, char_data valid
//  char_data   in   8      ASCII character to buffer
//  char_ready  out  1      FIFO accepts a push this cycle
//  flush       in   1      start clear+text sequence (level-sampled in IDLE)
//  count       out  $clog2(DEPTH+1)  characters currently buffered
//  busy        out  1      sequence in progress (state != IDLE)
//  done        out  1      one-cycle pulse: sequence completed with no NAK
//  error       out  1      sticky: NAK seen; cleared when the next flush is accepted
//  tx_start    out  1      one-cycle pulse: byte engine sends tx_data
//  tx_data     out  8      byte to send; held stable from tx_start until tx_done
//  tx_first    out  1      engine issues START before this byte (held like tx_data)
//  tx_last     out  1      engine issues STOP after this byte (held like tx_data)
//  tx_done     in   1      one-cycle pulse: byte (incl. ACK slot, STOP if last) finished
//  tx_nak      in   1      qualifies tx_done: target NAKed the byte
// BEHAVIOUR
//  Reset (reset=0): state IDLE, FIFO empty, count=0, char_ready=1, busy=0, done=0,
//   error=0, tx_start=0, tx_data=8'h00, tx_first=0, tx_last=0, gap counter 0.
//  FIFO: push when char_valid & char_ready; char_ready = ~full & (state==IDLE).
//   Pop only in TXT_CHAR on tx_done without NAK. Pointers wrap modulo DEPTH.
//   count is always the exact occupancy (0..DEPTH).
//  FSM: IDLE -> CLR_ADDR -> CLR_CMD -> CLR_CODE -> GAP -> TXT_ADDR -> TXT_CHAR -> IDLE.
//   IDLE: on flush, clear error and go to CLR_ADDR. If flush and a push occur in the
//    same cycle, the pushed char is included in the text.
//   Each send state: on entry, pulse tx_start for 1 cycle with tx_data/first/last
//    set, then wait for tx_done; tx_done when no byte is outstanding is ignored.
//   CLR_ADDR: data=E4, first=1. CLR_CMD: data=CMD_PREFIX. CLR_CODE: data=CLEAR_CMD, last=1.
//   GAP: count GAP_CYCLES clocks, then go to TXT_ADDR; if FIFO empty, go to IDLE
//    instead, pulse done, and send no text transaction.
//   TXT_ADDR: data=E4, first=1, last=0. TXT_CHAR: data=FIFO head; last=1 iff count==1.
//    Pop on each tx_done. Loop until the byte sent with last=1 completes -> IDLE, done=1 (1 cycle).
//  NAK (tx_done & tx_nak) in any send state: error<=1, FIFO cleared (count=0),
//   state<=IDLE, no done pulse. The engine owns STOP generation on NAK.
//  tx_nak without tx_done has no effect. flush while busy is ignored (not queued).
//  done and tx_start never assert in the same cycle as reset release.
//  Asserting reset mid-sequence returns everything to reset values immediately.
//   Any in-flight engine byte is abandoned; the engine resets on the same reset.
//  Byte latency: tx_start asserts exactly 1 cycle after the state transition that
//   requests the byte (i.e. 1 cycle after the previous tx_done).
// TESTING
//  1) Push "HELLO" (48 45 4C 4C 4F) then flush; engine ACKs all bytes
//     -> tx_data stream E4 7C 2D | E4 48 45 4C 4C 4F.
//     -> first on bytes 1 and 4, last on bytes 3 and 9.
//     -> >=500 idle clocks between 2D done and second E4 start; done pulses once; count=0.
//  2) Flush with empty FIFO -> E4 7C 2D only (last on 2D), GAP elapses, done=1, no 2nd E4.
//  3) Push 16 chars -> count=16, char_ready=0; 17th push dropped.
//     Flush -> 16 chars sent in order, pointer wrap verified, count returns to 0.
//  4) NAK on first E4 -> error=1, busy=0, count=0, no done.
//     Next flush clears error; the rerun with ACKs completes with done.
//  5) Push 'A' and assert flush in the same cycle -> text transaction E4 41 (last on 41).
//     char_valid while busy -> char_ready=0, count unchanged.
//  6) Assert reset during TXT_CHAR with 3 chars left -> all outputs at reset values
//     next edge, count=0, char_ready=1; post-reset flush behaves as scenario 2.

Source files
------------

// File: rtl/lcd_text_sequencer.sv
// lcd_text_sequencer: buffers LCD text, then drives a clear transaction and a text
// transaction through the byte-level I2C write engine handshake.
module lcd_text_sequencer #(
    parameter int         DEPTH      = 16,
    parameter logic [6:0] LCD_ADDR   = 7'h72,
    parameter logic [7:0] CMD_PREFIX = 8'h7C,
    parameter logic [7:0] CLEAR_CMD  = 8'h2D,
    parameter int         GAP_CYCLES = 500
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       char_valid,
    input  logic [7:0]                 char_data,
    output logic                       char_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic                       tx_first,
    output logic                       tx_last,
    input  logic                       tx_done,
    input  logic                       tx_nak
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [7:0] ADDR_BYTE = {LCD_ADDR, 1'b0};

    typedef enum logic [2:0] {IDLE, CLR_ADDR, CLR_CMD, CLR_CODE, GAP, TXT_ADDR, TXT_CHAR} state_t;

    state_t state, state_next;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [GW-1:0] gap_cnt;
    logic sent, send, ack, nak, issue, push, pop, gap_end, done_next;
    logic [7:0] byte_next;

    assign char_ready = (count != FULL) && (state == IDLE);
    assign busy = state != IDLE;

    // sent marks a byte handed to the engine and not yet finished; tx_done is only honoured then
    always_comb begin
        send = (state != IDLE) && (state != GAP);
        ack = tx_done & sent;
        nak = ack & tx_nak;
        issue = send & ~sent;
        push = char_valid & char_ready;
        pop = ack & ~tx_nak & (state == TXT_CHAR);
        gap_end = (state == GAP) && (gap_cnt == GAP_LAST);
        byte_next = state == CLR_CMD ? CMD_PREFIX :
                    state == CLR_CODE ? CLEAR_CMD :
                    state == TXT_CHAR ? mem[rd_ptr] : ADDR_BYTE;
        done_next = (gap_end && count == '0) || (pop && tx_last);
        state_next = state;
        case (state)
            IDLE:     if (flush) state_next = CLR_ADDR;
            CLR_ADDR: if (ack) state_next = CLR_CMD;
            CLR_CMD:  if (ack) state_next = CLR_CODE;
            CLR_CODE: if (ack) state_next = GAP;
            GAP:      if (gap_end) state_next = (count == '0) ? IDLE : TXT_ADDR;
            TXT_ADDR: if (ack) state_next = TXT_CHAR;
            TXT_CHAR: if (ack && tx_last) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (nak) state_next = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            gap_cnt  <= '0;
            sent     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            tx_first <= 1'b0;
            tx_last  <= 1'b0;
        end else begin
            state    <= state_next;
            done     <= done_next;
            tx_start <= issue;
            if (issue) begin
                sent     <= 1'b1;
                tx_data  <= byte_next;
                tx_first <= (state == CLR_ADDR) || (state == TXT_ADDR);
                tx_last  <= (state == CLR_CODE) || (state == TXT_CHAR && count == CW'(1));
            end else if (ack) begin
                sent <= 1'b0;
            end
            gap_cnt <= (state == GAP && !gap_end) ? gap_cnt + GW'(1) : '0;
            if (nak) error <= 1'b1;
            else if (state == IDLE && flush) error <= 1'b0;
            if (nak) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + CW'(1);
            end else if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                count  <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= char_data;
    end
endmodule

// File: tb/tb_lcd_text_sequencer.sv
// tb_lcd_text_sequencer: directed scenarios with random characters and engine latency,
// checked against a queue-based model of the expected I2C byte stream.
module tb_lcd_text_sequencer;
    localparam int DEPTH = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_data = 8'h00;
    logic       char_ready;
    logic       flush = 1'b0;
    logic [4:0] count;
    logic       busy, done, error, tx_start, tx_first, tx_last;
    logic [7:0] tx_data;
    logic       tx_done, tx_nak;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int nak_idx = -1;
    logic [7:0] mq[$];
    logic [7:0] log_d[$];
    logic       log_f[$];
    logic       log_l[$];
    int         log_cyc[$];
    int         dcyc[int];

    lcd_text_sequencer dut (
        .clock(clock), .reset(reset), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .flush(flush), .count(count), .busy(busy), .done(done),
        .error(error), .tx_start(tx_start), .tx_data(tx_data), .tx_first(tx_first),
        .tx_last(tx_last), .tx_done(tx_done), .tx_nak(tx_nak)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte engine: random latency, NAK on a chosen byte, stray tx_nak and unsolicited tx_done noise
    initial begin : engine
        int  wait_n;
        bit  pend;
        pend = 1'b0;
        wait_n = 0;
        tx_done = 1'b0;
        tx_nak = 1'b0;
        forever begin
            @(posedge clock); #1;
            cyc++;
            tx_done = 1'b0;
            tx_nak = ($urandom_range(0, 3) == 0);
            if (!reset) begin
                pend = 1'b0;
                tx_nak = 1'b0;
            end else if (tx_start) begin
                log_d.push_back(tx_data);
                log_f.push_back(tx_first);
                log_l.push_back(tx_last);
                log_cyc.push_back(cyc);
                pend = 1'b1;
                wait_n = $urandom_range(1, 4);
            end else if (pend) begin
                wait_n--;
                if (wait_n == 0) begin
                    pend = 1'b0;
                    tx_done = 1'b1;
                    tx_nak = (log_d.size() - 1 == nak_idx);
                    dcyc[log_d.size() - 1] = cyc;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                tx_done = 1'b1;
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_ready"}, char_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_tx_first"}, tx_first, 0);
        chk({tag, "_tx_last"}, tx_last, 0);
    endtask

    task automatic push(input logic [7:0] ch);
        bit exp_rdy;
        exp_rdy = (mq.size() < DEPTH);
        char_valid = 1'b1;
        char_data = ch;
        chk("push_ready", char_ready, exp_rdy);
        @(posedge clock); #1;
        char_valid = 1'b0;
        if (exp_rdy) mq.push_back(ch);
        chk("push_count", count, mq.size());
    endtask

    task automatic run_flush(input int nak_at, input bit with_push, input logic [7:0] ch);
        int base, dbase, n, exp_n;
        logic [7:0] ed[$];
        bit ef[$], el[$];
        base = log_d.size();
        dbase = done_cnt;
        nak_idx = (nak_at < 0) ? -1 : base + nak_at;
        if (with_push) begin
            char_valid = 1'b1;
            char_data = ch;
            if (mq.size() < DEPTH) mq.push_back(ch);
        end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        char_valid = 1'b0;
        chk("flush_busy", busy, 1);
        chk("flush_error_cleared", error, 0);
        chk("flush_count", count, mq.size());
        char_valid = 1'b1;
        char_data = 8'h5A;
        chk("busy_ready", char_ready, 0);
        @(posedge clock); #1;
        char_valid = 1'b0;
        chk("busy_count", count, mq.size());
        ed.push_back(8'hE4); ef.push_back(1'b1); el.push_back(1'b0);
        ed.push_back(8'h7C); ef.push_back(1'b0); el.push_back(1'b0);
        ed.push_back(8'h2D); ef.push_back(1'b0); el.push_back(1'b1);
        if (mq.size() > 0) begin
            ed.push_back(8'hE4); ef.push_back(1'b1); el.push_back(1'b0);
            foreach (mq[i]) begin
                ed.push_back(mq[i]);
                ef.push_back(1'b0);
                el.push_back(i == mq.size() - 1);
            end
        end
        n = 0;
        while (busy && n < 5000) begin
            @(posedge clock); #1;
            n++;
        end
        chk("seq_timeout", n < 5000, 1);
        repeat (2) @(posedge clock);
        #1;
        exp_n = (nak_at < 0) ? ed.size() : nak_at + 1;
        chk("bytes_sent", log_d.size() - base, exp_n);
        for (int i = 0; i < exp_n && base + i < log_d.size(); i++) begin
            chk($sformatf("byte%0d_data", i), log_d[base + i], ed[i]);
            chk($sformatf("byte%0d_first", i), log_f[base + i], ef[i]);
            chk($sformatf("byte%0d_last", i), log_l[base + i], el[i]);
        end
        chk("done_pulses", done_cnt - dbase, (nak_at < 0) ? 1 : 0);
        chk("end_error", error, (nak_at >= 0) ? 1 : 0);
        chk("end_busy", busy, 0);
        chk("end_count", count, 0);
        chk("end_ready", char_ready, 1);
        if (nak_at < 0 && ed.size() > 3 && log_d.size() - base > 3 && dcyc.exists(base + 2))
            chk("gap_ge_500", (log_cyc[base + 3] - dcyc[base + 2]) >= 500, 1);
        mq.delete();
    endtask

    initial begin : main
        int n, len, nk;
        repeat (3) @(posedge clock);
        #1;
        chk_reset_vals("reset");
        reset = 1'b1;
        @(posedge clock); #1;
        chk("post_release_tx_start", tx_start, 0);
        chk("post_release_done", done, 0);

        // HELLO through both transactions
        push(8'h48); push(8'h45); push(8'h4C); push(8'h4C); push(8'h4F);
        run_flush(-1, 1'b0, 8'h00);

        // empty FIFO: clear only
        run_flush(-1, 1'b0, 8'h00);

        // fill to DEPTH with random chars, 17th dropped, pointers wrap
        for (int i = 0; i < DEPTH + 1; i++) push(8'($urandom_range(32, 126)));
        chk("full_count", count, DEPTH);
        chk("full_ready", char_ready, 0);
        run_flush(-1, 1'b0, 8'h00);

        // NAK on the first address byte, then clean rerun
        push(8'($urandom_range(32, 126)));
        push(8'($urandom_range(32, 126)));
        run_flush(0, 1'b0, 8'h00);
        push(8'($urandom_range(32, 126)));
        push(8'($urandom_range(32, 126)));
        run_flush(-1, 1'b0, 8'h00);

        // push and flush in the same cycle
        run_flush(-1, 1'b1, 8'h41);

        // random lengths with occasional NAK anywhere
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(0, DEPTH);
            for (int i = 0; i < n; i++) push(8'($urandom_range(32, 126)));
            len = 3 + ((n > 0) ? n + 1 : 0);
            nk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_flush(nk, 1'b0, 8'h00);
        end

        // reset during text with 3 chars left
        for (int i = 0; i < 5; i++) push(8'($urandom_range(32, 126)));
        nak_idx = -1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        n = 0;
        while (count != 3 && n < 5000) begin
            @(posedge clock); #1;
            n++;
        end
        chk("reach_3_left", n < 5000, 1);
        #2 reset = 1'b0;
        #1 chk_reset_vals("mid_reset");
        @(posedge clock); #1;
        chk_reset_vals("mid_reset_edge");
        reset = 1'b1;
        mq.delete();
        @(posedge clock); #1;
        chk("rerelease_tx_start", tx_start, 0);
        chk("rerelease_done", done, 0);
        run_flush(-1, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
